out_dec_scan: RTL and testbench
===============================

Name: out_dec_scan

Overview:
- Display stage directly downstream of the processor. Consumes processor outputs `outval1`, `outval2`, `outsel` and the strobe `outdisplay`.
- Converts both values to decimal with a sequential double-dabble converter, then drives one time-multiplexed 8-digit 7-segment display.
- Offers a busy/pending handshake so strobes arriving during a conversion are not lost.

Parameters:
- SCAN_DIV, 1024: clocks per digit slot in the scan; must be ≥ 2.
- BLANK_LZ, 1: 1 blanks leading zeros within each field; the field's least-significant digit is never blanked.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- outval1  in  16  value for the left field, unsigned
- outval2  in  16  value for the right field; only [7:0] is used, [15:8] is ignored
- outsel  in  3  digit index (0..7) whose decimal point is lit
- outdisplay  in  1  one-cycle strobe; update the display with the current inputs
- busy  out  1  a conversion is in progress
- seg  out  8  segment drive {dp,g,f,e,d,c,b,a}, active-high, registered
- seg_sel  out  8  one-hot digit select, active-high, registered; bit i = digit i

Behaviour:
- Clocking and reset: one clock. Reset is synchronous and active-high. All state is cleared on the edge where reset is sampled high.
- Values after reset:
  - busy=0, pending=0, dp_en=0, dp_pos=0.
  - All committed BCD digits are 0.
  - Scan index 0, prescaler 0, seg_sel=8'h01.
  - seg = 8'h3F, i.e. digit 0 showing "0".
- Display layout:
  - Digits 7..3: outval1 in decimal, 5 digits, range 0..65535; digit 3 is the LSD.
  - Digits 2..0: outval2[7:0] in decimal, 3 digits, range 0..255; digit 0 is the LSD.
- FSM states: IDLE, CONV, COMMIT.
- IDLE:
  - outdisplay=1 at edge k: latch outval1, outval2[7:0] and outsel into the converters and the dp register.
  - Go to CONV; busy=1 after edge k.
- CONV:
  - 16 shift edges, k+1..k+16. Each edge applies add-3 to every BCD nibble ≥ 5, then shifts in one bit MSB-first.
  - The 8-bit converter pre-pads its input with 8 leading zeros so both converters finish together.
- COMMIT (edge k+17):
  - Copy the BCD results into the display digit registers; set dp_en=1 and dp_pos = the latched outsel.
  - New digits are visible from edge k+17.
  - Next state at the same edge:
    - if outdisplay=1, start a new conversion from the live inputs and clear pending;
    - else if pending=1, start from the pending registers and clear pending;
    - else go to IDLE with busy=0.
- Strobes while busy (CONV, or COMMIT handled as above):
  - outdisplay=1 in CONV copies the inputs into the pending registers and sets pending=1.
  - A later strobe overwrites the pending registers; the latest strobe wins and the queue depth is 1.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1. At wrap, the scan index increments and wraps 7→0.
  - seg_sel = one-hot of the index.
  - seg = decode(digit[index]) | (dp_en && dp_pos==index ? 8'h80 : 0).
  - Both seg and seg_sel are registered; they update on the same edge as the index.
  - The scan never stalls for conversion; a commit is simply reflected at the next registered refresh.
- Segment codes (a..g), 0-9: 3F 06 5B 4F 66 6D 7D 07 7F 6F. Blanked digit = 00, but its dp still follows dp_pos.
- Blanking (BLANK_LZ=1): within each field, zeros above the highest non-zero digit are blanked. A field equal to 0 shows a single "0" at its LSD.
- Reset mid-conversion: abort, return to the reset values above. The conversion is not completed.

Decomposition:
- Package `out_dec_pkg`:
  - FSM state encoding (IDLE/CONV/COMMIT);
  - the 10-entry segment constant table and SEG_BLANK=8'h00;
  - SHIFT_CYCLES=16;
  - field boundary constants (LEFT_LSD=3, RIGHT_LSD=0).
- Sub-module `bcd_seq_conv`:
  - parameters WIDTH and DIGITS;
  - ports clock, reset, load, shift, bin_in, bcd_out;
  - instantiated twice (16/5 and 8/3, the latter with zero pre-padding).
  - The FSM, pending logic and scan live in the top.

Test Plan:
1. Reset for 2 cycles, SCAN_DIV=4 → busy=0, seg_sel=01 and seg=3F in the first cycle after reset. Over 8 slots, digits 7..4 and 2..1 show 00; digits 3 and 0 show 3F.
2. Conversion: outval1=12345, outval2=16'hAB12 (uses 8'h12=18), outsel=3, strobe at edge k → busy=1 during k+1..k+17, 0 after. Digits 7..3 = 06,5B,4F,66,ED (dp lit); digits 2..0 = 00,06,7F.
3. Boundaries:
   - outval1=65535, outval2=255 → 7D,6D,6D,4F,6D / 5B,6D,6D.
   - outval1=7, outval2=0 → digits 7..4 = 00, digit 3 = 07, digits 2..1 = 00, digit 0 = 3F.
4. Strobe A; strobe B at k+5; strobe C at k+9 → A commits at k+17. C (not B) starts at k+17 and commits at k+34. B is never displayed; busy stays 1 continuously until after k+34.
5. Strobe exactly at the commit edge with pending set → live inputs win and pending is cleared. Result commits 17 edges later; busy never drops in between.
6. Assert reset at k+8 mid-conversion → busy=0, digit registers back to zero, pending=0, seg_sel=01. A fresh strobe afterwards converts normally.

Source files
------------

// File: rtl/out_dec_pkg.sv
// out_dec_pkg
//   Shared definitions for the out_dec_scan display stage: controller state
//   encoding, conversion length, digit-field boundaries and the 7-segment
//   code table with its decode helper.
package out_dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Both converters run for the width of the wider input.
  localparam int SHIFT_CYCLES = 16;

  // Least-significant digit position of each display field.
  localparam int LEFT_LSD  = 3;
  localparam int RIGHT_LSD = 0;

  // Segment codes {dp,g,f,e,d,c,b,a} for 0..9; entry 0 sits in the low byte.
  localparam logic [9:0][7:0] SEG_TABLE = {
    8'h6F, 8'h7F, 8'h07, 8'h7D, 8'h6D, 8'h66, 8'h4F, 8'h5B, 8'h06, 8'h3F
  };
  localparam logic [7:0] SEG_BLANK = 8'h00;
  localparam logic [7:0] SEG_DP    = 8'h80;

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    if (d <= 4'd9) return SEG_TABLE[d];
    return SEG_BLANK;
  endfunction

endpackage

// File: rtl/out_dec_scan_bcd_seq_conv.sv
// bcd_seq_conv
//   Sequential double-dabble binary-to-BCD converter, one bit per shift.
//   Ports:
//     clock, reset  - clock and synchronous active-high reset
//     load          - capture bin_in and clear the BCD accumulator
//     shift         - one add-3/shift step, binary consumed MSB-first
//     bin_in        - unsigned binary value (WIDTH bits)
//     bcd_out       - DIGITS packed BCD nibbles, digit 0 in the low nibble
//   SHIFTS >= WIDTH widens the internal shift register with leading zeros so a
//   narrow converter can run the same number of steps as a wide one; leading
//   zero bits leave an all-zero accumulator unchanged.
module bcd_seq_conv #(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5,
  parameter int SHIFTS = WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  shift,
  input  logic [WIDTH-1:0]      bin_in,
  output logic [4*DIGITS-1:0]   bcd_out
);

  logic [SHIFTS-1:0]   sr_q;
  logic [4*DIGITS-1:0] bcd_q;
  logic [4*DIGITS-1:0] bcd_adj;

  // Add 3 to every nibble >= 5 so the following doubling carries correctly.
  always_comb begin
    bcd_adj = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (bcd_q[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd_q[4*d +: 4] + 4'd3;
      else                         bcd_adj[4*d +: 4] = bcd_q[4*d +: 4];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sr_q  <= '0;
      bcd_q <= '0;
    end else if (load) begin
      sr_q  <= SHIFTS'(bin_in);
      bcd_q <= '0;
    end else if (shift) begin
      bcd_q <= {bcd_adj[4*DIGITS-2:0], sr_q[SHIFTS-1]};
      sr_q  <= {sr_q[SHIFTS-2:0], 1'b0};
    end
  end

  assign bcd_out = bcd_q;

endmodule

// File: rtl/out_dec_scan.sv
// out_dec_scan
//   Display stage behind the processor: converts outval1 (16 bit) and
//   outval2[7:0] to decimal and scans them onto an 8-digit multiplexed
//   7-segment display (digits 7..3 = outval1, digits 2..0 = outval2[7:0]).
//   Ports:
//     clock, reset      - clock and synchronous active-high reset
//     outval1, outval2  - values to show (outval2[15:8] ignored)
//     outsel            - digit whose decimal point is lit
//     outdisplay        - one-cycle update strobe
//     busy              - conversion in progress
//     seg               - registered segment drive {dp,g,f,e,d,c,b,a}
//     seg_sel           - registered one-hot digit select
//   A strobe arriving mid-conversion is held in a one-deep pending slot
//   (latest wins) and started right after the current commit.
module out_dec_scan
  import out_dec_pkg::*;
#(
  parameter int SCAN_DIV = 1024,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] outval1,
  input  logic [15:0] outval2,
  input  logic [2:0]  outsel,
  input  logic        outdisplay,
  output logic        busy,
  output logic [7:0]  seg,
  output logic [7:0]  seg_sel
);

  localparam int PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic [15:0]      pv1_q, pv1_d;
  logic [7:0]       pv2_q, pv2_d;
  logic [2:0]       psel_q, psel_d;
  logic [2:0]       csel_q, csel_d;
  logic             dp_en_q;
  logic [2:0]       dp_pos_q;
  logic [7:0][3:0]  disp_q;
  logic [PW-1:0]    presc_q, presc_d;
  logic [2:0]       idx_q, idx_d;
  logic [7:0]       seg_q, seg_d;
  logic [7:0]       seg_sel_q, seg_sel_d;

  logic             conv_load, conv_shift, commit;
  logic [15:0]      ld_v1;
  logic [7:0]       ld_v2;
  logic [2:0]       ld_sel;
  logic [19:0]      bcd1;
  logic [11:0]      bcd2;
  logic [7:0]       blank;

  logic unused_ok;
  assign unused_ok = ^outval2[15:8];

  bcd_seq_conv #(.WIDTH(16), .DIGITS(5), .SHIFTS(SHIFT_CYCLES)) u_conv_left (
    .clock   (clock),
    .reset   (reset),
    .load    (conv_load),
    .shift   (conv_shift),
    .bin_in  (ld_v1),
    .bcd_out (bcd1)
  );

  bcd_seq_conv #(.WIDTH(8), .DIGITS(3), .SHIFTS(SHIFT_CYCLES)) u_conv_right (
    .clock   (clock),
    .reset   (reset),
    .load    (conv_load),
    .shift   (conv_shift),
    .bin_in  (ld_v2),
    .bcd_out (bcd2)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    pv1_d      = pv1_q;
    pv2_d      = pv2_q;
    psel_d     = psel_q;
    csel_d     = csel_q;
    conv_load  = 1'b0;
    conv_shift = 1'b0;
    commit     = 1'b0;
    ld_v1      = outval1;
    ld_v2      = outval2[7:0];
    ld_sel     = outsel;
    unique case (state_q)
      ST_IDLE: begin
        if (outdisplay) begin
          conv_load = 1'b1;
          state_d   = ST_CONV;
          cnt_d     = '0;
        end
      end
      ST_CONV: begin
        conv_shift = 1'b1;
        cnt_d      = cnt_q + 4'd1;
        if (cnt_q == 4'(SHIFT_CYCLES - 1)) state_d = ST_COMMIT;
        if (outdisplay) begin
          pend_d = 1'b1;
          pv1_d  = outval1;
          pv2_d  = outval2[7:0];
          psel_d = outsel;
        end
      end
      ST_COMMIT: begin
        commit = 1'b1;
        // A live strobe on the commit edge supersedes the pending request.
        if (outdisplay) begin
          conv_load = 1'b1;
          pend_d    = 1'b0;
          state_d   = ST_CONV;
          cnt_d     = '0;
        end else if (pend_q) begin
          ld_v1     = pv1_q;
          ld_v2     = pv2_q;
          ld_sel    = psel_q;
          conv_load = 1'b1;
          pend_d    = 1'b0;
          state_d   = ST_CONV;
          cnt_d     = '0;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (conv_load) csel_d = ld_sel;
  end

  // Leading-zero blanking: walk each field from its top digit down; the
  // field's LSD always shows.
  always_comb begin
    logic run;
    run   = 1'b0;
    blank = '0;
    for (int i = 7; i >= 0; i--) begin
      if (i == 7 || i == LEFT_LSD - 1) run = BLANK_LZ;
      run = run && (disp_q[i] == 4'd0);
      blank[i] = run && (i != LEFT_LSD) && (i != RIGHT_LSD);
    end
  end

  always_comb begin
    presc_d = presc_q + PW'(1);
    idx_d   = idx_q;
    if (presc_q == PW'(SCAN_DIV - 1)) begin
      presc_d = '0;
      idx_d   = idx_q + 3'd1;
    end
    seg_sel_d = 8'h01 << idx_d;
    seg_d     = blank[idx_d] ? SEG_BLANK : seg_decode(disp_q[idx_d]);
    if (dp_en_q && (dp_pos_q == idx_d)) seg_d = seg_d | SEG_DP;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      pv1_q     <= '0;
      pv2_q     <= '0;
      psel_q    <= '0;
      csel_q    <= '0;
      dp_en_q   <= 1'b0;
      dp_pos_q  <= '0;
      disp_q    <= '0;
      presc_q   <= '0;
      idx_q     <= '0;
      seg_q     <= 8'h3F;
      seg_sel_q <= 8'h01;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      pv1_q     <= pv1_d;
      pv2_q     <= pv2_d;
      psel_q    <= psel_d;
      csel_q    <= csel_d;
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      seg_q     <= seg_d;
      seg_sel_q <= seg_sel_d;
      if (commit) begin
        for (int d = 0; d < 5; d++) disp_q[LEFT_LSD + d]  <= bcd1[4*d +: 4];
        for (int d = 0; d < 3; d++) disp_q[RIGHT_LSD + d] <= bcd2[4*d +: 4];
        dp_en_q  <= 1'b1;
        dp_pos_q <= csel_q;
      end
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign seg     = seg_q;
  assign seg_sel = seg_sel_q;

endmodule

// File: tb/tb_out_dec_scan.sv
// tb_out_dec_scan
//   Directed bench for out_dec_scan with a short scan period. Inputs change on
//   the falling edge; outputs are sampled on the falling edge.
module tb_out_dec_scan;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] outval1 = '0;
  logic [15:0] outval2 = '0;
  logic [2:0]  outsel = '0;
  logic        outdisplay = 1'b0;
  logic        busy;
  logic [7:0]  seg;
  logic [7:0]  seg_sel;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_seg [8];

  out_dec_scan #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
    .clock      (clock),
    .reset      (reset),
    .outval1    (outval1),
    .outval2    (outval2),
    .outsel     (outsel),
    .outdisplay (outdisplay),
    .busy       (busy),
    .seg        (seg),
    .seg_sel    (seg_sel)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_exp(input logic [7:0] e7, e6, e5, e4, e3, e2, e1, e0);
    exp_seg[7] = e7; exp_seg[6] = e6; exp_seg[5] = e5; exp_seg[4] = e4;
    exp_seg[3] = e3; exp_seg[2] = e2; exp_seg[1] = e1; exp_seg[0] = e0;
  endtask

  // Compare the currently selected digit against the expected table.
  task automatic scan_now(input string tag);
    int idx = -1;
    for (int i = 0; i < 8; i++) if (seg_sel === (8'h01 << i)) idx = i;
    if (idx < 0) chk({tag, "_sel"}, seg_sel, 8'h01);
    else         chk($sformatf("%s_d%0d", tag, idx), seg, exp_seg[idx]);
  endtask

  task automatic check_display(input string tag);
    repeat (32) begin
      @(negedge clock);
      scan_now(tag);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic tick_busy(input int n, input logic e, input string tag);
    repeat (n) begin
      @(negedge clock);
      chk(tag, {7'd0, busy}, {7'd0, e});
    end
  endtask

  // Called on a falling edge; the strobe is seen by the next rising edge.
  task automatic strobe(input logic [15:0] v1, input logic [15:0] v2, input logic [2:0] s);
    outval1 = v1; outval2 = v2; outsel = s; outdisplay = 1'b1;
    @(negedge clock);
    outdisplay = 1'b0;
  endtask

  initial begin
    // Reset state and the all-zero display
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_sel", seg_sel, 8'h01);
    chk("rst_seg", seg, 8'h3F);
    set_exp(8'h00, 8'h00, 8'h00, 8'h00, 8'h3F, 8'h00, 8'h00, 8'h3F);
    check_display("rst");

    // 12345 / 18, dp on digit 3
    strobe(16'd12345, 16'hAB12, 3'd3);
    chk("t2_busy0", {7'd0, busy}, 8'h01);
    tick_busy(16, 1'b1, "t2_busy");
    tick_busy(1, 1'b0, "t2_idle");
    set_exp(8'h06, 8'h5B, 8'h4F, 8'h66, 8'hED, 8'h00, 8'h06, 8'h7F);
    check_display("t2");

    // Maximum values, dp on digit 0
    strobe(16'd65535, 16'd255, 3'd0);
    tick_busy(16, 1'b1, "t3a_busy");
    tick_busy(1, 1'b0, "t3a_idle");
    set_exp(8'h7D, 8'h6D, 8'h6D, 8'h4F, 8'h6D, 8'h5B, 8'h6D, 8'hED);
    check_display("t3a");

    // A at k, B at k+5, C at k+9: A shows, then C; B never shows
    strobe(16'd1, 16'd2, 3'd7);
    tick_busy(4, 1'b1, "t4_busyA");
    strobe(16'd99, 16'd99, 3'd0);
    tick_busy(3, 1'b1, "t4_busyB");
    strobe(16'd40000, 16'd200, 3'd1);
    tick_busy(9, 1'b1, "t4_busyC");
    set_exp(8'h80, 8'h00, 8'h00, 8'h00, 8'h06, 8'h00, 8'h00, 8'h5B);
    repeat (15) begin
      @(negedge clock);
      chk("t4_busy_gap", {7'd0, busy}, 8'h01);
      scan_now("t4A");
    end
    tick_busy(1, 1'b0, "t4_idle");
    tick(1);
    set_exp(8'h66, 8'h3F, 8'h3F, 8'h3F, 8'h3F, 8'h5B, 8'hBF, 8'h3F);
    check_display("t4C");

    // D at k, E pending at k+3, F live on the commit edge k+17
    strobe(16'd500, 16'd0, 3'd2);
    tick(2);
    strobe(16'd11111, 16'd11, 3'd5);
    tick_busy(13, 1'b1, "t5_busyD");
    strobe(16'd60000, 16'd100, 3'd6);
    tick_busy(16, 1'b1, "t5_busyF");
    tick_busy(1, 1'b0, "t5_idle");
    tick(1);
    set_exp(8'h7D, 8'hBF, 8'h3F, 8'h3F, 8'h3F, 8'h06, 8'h3F, 8'h3F);
    check_display("t5F");

    // Reset at k+8 with a pending request queued
    strobe(16'd65535, 16'd255, 3'd0);
    tick(3);
    strobe(16'd321, 16'd45, 3'd4);
    tick(3);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    chk("t6_busy", {7'd0, busy}, 8'h00);
    chk("t6_sel", seg_sel, 8'h01);
    chk("t6_seg", seg, 8'h3F);
    tick_busy(20, 1'b0, "t6_stay_idle");
    set_exp(8'h00, 8'h00, 8'h00, 8'h00, 8'h3F, 8'h00, 8'h00, 8'h3F);
    check_display("t6_clr");

    // Fresh strobe after abort: 7 / 0, dp on digit 4
    strobe(16'd7, 16'd0, 3'd4);
    tick_busy(16, 1'b1, "t3b_busy");
    tick_busy(1, 1'b0, "t3b_idle");
    set_exp(8'h00, 8'h00, 8'h00, 8'h80, 8'h07, 8'h00, 8'h00, 8'h3F);
    check_display("t3b");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
